// File: rtl/prog_fetch_pkg.sv
// Shared constants, state encodings and sizing helpers for the program
// fetch unit and its instruction store.
package prog_fetch_pkg;

  // Sequencer state encoding.
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_PROG = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_HALT = 2'd3;

  // Instruction encoding that stops the sequencer unless overridden.
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Bytes per instruction word.
  function automatic int calc_bpi(input int inst_w);
    return inst_w / 8;
  endfunction

  // Number of addressable bytes in the instruction store.
  function automatic int calc_span(input int depth, input int inst_w);
    return depth * (inst_w / 8);
  endfunction

  // Width of a word index; never narrower than one bit.
  function automatic int calc_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a byte-lane select; never narrower than one bit.
  function automatic int calc_lane_w(input int inst_w);
    return (inst_w > 8) ? $clog2(inst_w / 8) : 1;
  endfunction

endpackage

// File: rtl/fetch_mem.sv
// Instruction store: DEPTH words of INST_W bits held in flops that clear
// on reset, with one byte-lane write port, a word read port for fetch and
// a byte read port for programming readback. Reads are combinational; the
// caller registers them.
module fetch_mem
  import prog_fetch_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = calc_idx_w(DEPTH),
  parameter int LANE_W = calc_lane_w(INST_W)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [LANE_W-1:0] i_wr_lane,
  input  logic [7:0]        i_wr_data,
  input  logic [IDX_W-1:0]  i_word_idx,
  output logic [INST_W-1:0] o_word,
  input  logic [IDX_W-1:0]  i_byte_idx,
  input  logic [LANE_W-1:0] i_byte_lane,
  output logic [7:0]        o_byte
);

  localparam int BPI = calc_bpi(INST_W);

  logic [INST_W-1:0] word_w [DEPTH];
  logic [INST_W-1:0] byte_word;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [INST_W-1:0] word_q;

    // Write the addressed byte lane of this word; reset wipes the word.
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        word_q <= '0;
      end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
        for (int li = 0; li < BPI; li++) begin
          if (i_wr_lane == LANE_W'(li)) begin
            word_q[li*8 +: 8] <= i_wr_data;
          end
        end
      end
    end

    assign word_w[gi] = word_q;
  end

  // Word read for fetch and little-endian byte pick for readback.
  always_comb begin
    o_word    = word_w[i_word_idx];
    byte_word = word_w[i_byte_idx];
    o_byte    = byte_word[{i_byte_lane, 3'b000} +: 8];
  end

endmodule

// File: rtl/prog_fetch_unit.sv
// Program counter, byte-programmable instruction store and fetch sequencer.
// Modes: idle, programming (byte writes from the programming port), run
// (one registered fetch per cycle with branch redirect) and halt (entered
// when the halt encoding is fetched). Readback of any byte works in every
// mode and is registered.
module prog_fetch_unit
  import prog_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                INST_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                PC_STEP   = 4,
  parameter logic [INST_W-1:0] HALT_WORD = INST_W'(DEFAULT_HALT_WORD)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_prog_mode,
  input  logic              i_run,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  output logic              o_halt,
  output logic              o_prog_err
);

  localparam int BPI    = calc_bpi(INST_W);
  localparam int SPAN   = calc_span(DEPTH, INST_W);
  localparam int IDX_W  = calc_idx_w(DEPTH);
  localparam int LANE_W = calc_lane_w(INST_W);

  // Address arithmetic runs one bit wider so SPAN itself is representable.
  localparam logic [ADDR_W:0] SPAN_L    = (ADDR_W+1)'(SPAN);
  localparam logic [ADDR_W:0] BPI_L     = (ADDR_W+1)'(BPI);
  localparam logic [ADDR_W:0] PC_STEP_L = (ADDR_W+1)'(PC_STEP);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                halt_q, halt_d;
  logic                err_q, err_d;
  logic [7:0]          rd_q, rd_d;

  logic [ADDR_W:0]     wr_addr_x;
  logic [ADDR_W:0]     rd_addr_x;
  logic [ADDR_W:0]     pc_x;
  logic [ADDR_W:0]     tgt_x;
  logic                wr_in_range;
  logic                rd_in_range;
  logic [IDX_W-1:0]    wr_idx;
  logic [LANE_W-1:0]   wr_lane;
  logic [IDX_W-1:0]    rd_idx;
  logic [LANE_W-1:0]   rd_lane;
  logic [IDX_W-1:0]    fetch_idx;
  logic [ADDR_W-1:0]   seq_next;
  logic [ADDR_W-1:0]   branch_next;
  logic                mem_we;
  logic [INST_W-1:0]   fetch_word;
  logic [7:0]          mem_byte;

  // Split byte addresses into word index and lane, and derive next PCs.
  always_comb begin
    wr_addr_x   = {1'b0, i_wr_addr};
    rd_addr_x   = {1'b0, i_rd_addr};
    pc_x        = {1'b0, pc_q};
    tgt_x       = {1'b0, i_branch_target};
    wr_in_range = (wr_addr_x < SPAN_L);
    rd_in_range = (rd_addr_x < SPAN_L);
    wr_idx      = IDX_W'(wr_addr_x / BPI_L);
    wr_lane     = LANE_W'(wr_addr_x % BPI_L);
    rd_idx      = IDX_W'(rd_addr_x / BPI_L);
    rd_lane     = LANE_W'(rd_addr_x % BPI_L);
    fetch_idx   = IDX_W'(pc_x / BPI_L);
    seq_next    = ADDR_W'((pc_x + PC_STEP_L) % SPAN_L);
    // Branch targets are word-aligned by dropping the lane offset.
    branch_next = ADDR_W'((tgt_x - (tgt_x % BPI_L)) % SPAN_L);
  end

  fetch_mem #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .LANE_W (LANE_W)
  ) u_mem (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_wr_en     (mem_we),
    .i_wr_idx    (wr_idx),
    .i_wr_lane   (wr_lane),
    .i_wr_data   (i_wr_data),
    .i_word_idx  (fetch_idx),
    .o_word      (fetch_word),
    .i_byte_idx  (rd_idx),
    .i_byte_lane (rd_lane),
    .o_byte      (mem_byte)
  );

  // Sequencer: programming beats halt handling, which beats the run request.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_pc_d = out_pc_q;
    inst_d   = inst_q;
    valid_d  = 1'b0;
    halt_d   = halt_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_prog_mode) begin
          state_d = S_PROG;
          pc_d    = '0;
          err_d   = 1'b0;
        end else if (i_run) begin
          state_d = S_RUN;
        end
      end

      S_PROG: begin
        if (i_wr_en) begin
          if (wr_in_range) begin
            mem_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (!i_prog_mode) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (i_prog_mode) begin
          state_d = S_PROG;
          pc_d    = '0;
          err_d   = 1'b0;
        end else if (!i_run) begin
          state_d = S_IDLE;
        end else begin
          out_pc_d = pc_q;
          inst_d   = fetch_word;
          valid_d  = 1'b1;
          if (fetch_word == HALT_WORD) begin
            // Present the halt word, then park without advancing the PC.
            halt_d  = 1'b1;
            state_d = S_HALT;
          end else if (i_branch_en) begin
            pc_d = branch_next;
          end else begin
            pc_d = seq_next;
          end
        end
      end

      S_HALT: begin
        if (i_prog_mode) begin
          state_d = S_PROG;
          pc_d    = '0;
          err_d   = 1'b0;
          halt_d  = 1'b0;
        end else if (!i_run) begin
          state_d = S_IDLE;
          pc_d    = '0;
          halt_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Readback returns the pre-write byte; out-of-range addresses read zero.
  always_comb begin
    rd_d = rd_in_range ? mem_byte : 8'h00;
  end

  // Sequencer, PC and output registers; reset clears them immediately.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      out_pc_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  assign o_pc         = out_pc_q;
  assign o_inst       = inst_q;
  assign o_inst_valid = valid_q;
  assign o_halt       = halt_q;
  assign o_prog_err   = err_q;
  assign o_rd_data    = rd_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Scoreboard bench for prog_fetch_unit: the driver applies inputs on the
// falling edge, advances a byte-level reference model and queues the
// expected post-edge outputs; the monitor samples just after each rising
// edge and compares.
module tb_prog_fetch_unit;

  localparam int SPAN    = 64;
  localparam int BPI     = 4;
  localparam int PC_STEP = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  localparam int M_IDLE = 0;
  localparam int M_PROG = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b1;
  logic        i_prog_mode = 1'b0;
  logic        i_run = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [7:0]  i_wr_addr = 8'h00;
  logic [7:0]  i_wr_data = 8'h00;
  logic [7:0]  i_rd_addr = 8'h00;
  logic        i_branch_en = 1'b0;
  logic [7:0]  i_branch_target = 8'h00;
  logic [7:0]  o_rd_data;
  logic [7:0]  o_pc;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic        o_halt;
  logic        o_prog_err;

  always #5 i_clk = ~i_clk;

  prog_fetch_unit dut (
    .i_clk           (i_clk),
    .i_nrst          (i_nrst),
    .i_prog_mode     (i_prog_mode),
    .i_run           (i_run),
    .i_wr_en         (i_wr_en),
    .i_wr_addr       (i_wr_addr),
    .i_wr_data       (i_wr_data),
    .i_rd_addr       (i_rd_addr),
    .o_rd_data       (o_rd_data),
    .i_branch_en     (i_branch_en),
    .i_branch_target (i_branch_target),
    .o_pc            (o_pc),
    .o_inst          (o_inst),
    .o_inst_valid    (o_inst_valid),
    .o_halt          (o_halt),
    .o_prog_err      (o_prog_err)
  );

  typedef struct {
    logic        valid;
    logic        halt;
    logic        err;
    logic [7:0]  rd;
    logic [7:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: byte-addressed store plus mode and program counter.
  logic [7:0]  m_mem [SPAN];
  int          m_mode;
  int          m_pc;
  logic [7:0]  m_opc;
  logic [31:0] m_inst;
  logic        m_halt;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < SPAN; a++) m_mem[a] = 8'h00;
    m_mode = M_IDLE;
    m_pc   = 0;
    m_opc  = 8'h00;
    m_inst = 32'h0;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_enter_prog();
    m_mode = M_PROG;
    m_pc   = 0;
    m_err  = 1'b0;
    m_halt = 1'b0;
  endtask

  // One clock of stimulus with the model's prediction for the next edge.
  task automatic step(input logic prog, input logic run, input logic we,
                      input logic [7:0] wa, input logic [7:0] wd,
                      input logic [7:0] ra, input logic br, input logic [7:0] bt);
    exp_t        e;
    logic [31:0] w;
    logic        fetched;
    @(negedge i_clk);
    i_nrst = 1'b1;
    i_prog_mode = prog;
    i_run = run;
    i_wr_en = we;
    i_wr_addr = wa;
    i_wr_data = wd;
    i_rd_addr = ra;
    i_branch_en = br;
    i_branch_target = bt;
    fetched = 1'b0;
    e.rd = (int'(ra) < SPAN) ? m_mem[ra] : 8'h00;
    case (m_mode)
      M_IDLE: begin
        if (prog) model_enter_prog();
        else if (run) m_mode = M_RUN;
      end
      M_PROG: begin
        if (we) begin
          if (int'(wa) < SPAN) m_mem[wa] = wd;
          else m_err = 1'b1;
        end
        if (!prog) m_mode = M_IDLE;
      end
      M_RUN: begin
        if (prog) model_enter_prog();
        else if (!run) m_mode = M_IDLE;
        else begin
          w = {m_mem[m_pc+3], m_mem[m_pc+2], m_mem[m_pc+1], m_mem[m_pc]};
          fetched = 1'b1;
          m_opc = 8'(m_pc);
          m_inst = w;
          if (w == HALT) begin
            m_halt = 1'b1;
            m_mode = M_HALT;
          end else if (br) begin
            m_pc = ((int'(bt) / BPI) * BPI) % SPAN;
          end else begin
            m_pc = (m_pc + PC_STEP) % SPAN;
          end
        end
      end
      default: begin
        if (prog) model_enter_prog();
        else if (!run) begin
          m_mode = M_IDLE;
          m_pc = 0;
          m_halt = 1'b0;
        end
      end
    endcase
    e.valid = fetched;
    e.halt  = m_halt;
    e.err   = m_err;
    e.pc    = m_opc;
    e.inst  = m_inst;
    exp_q.push_back(e);
  endtask

  // One clock with reset held low; everything reads as zero.
  task automatic step_rst();
    exp_t e;
    @(negedge i_clk);
    i_nrst = 1'b0;
    i_prog_mode = 1'b0;
    i_run = 1'b0;
    i_wr_en = 1'b0;
    i_branch_en = 1'b0;
    model_reset();
    e.valid = 1'b0;
    e.halt  = 1'b0;
    e.err   = 1'b0;
    e.rd    = 8'h00;
    e.pc    = 8'h00;
    e.inst  = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pc"},    o_pc, 32'h0);
    chk({tag, "_inst"},  o_inst, 32'h0);
    chk({tag, "_valid"}, o_inst_valid, 32'h0);
    chk({tag, "_halt"},  o_halt, 32'h0);
    chk({tag, "_err"},   o_prog_err, 32'h0);
    chk({tag, "_rd"},    o_rd_data, 32'h0);
  endtask

  // Assert reset between edges and require outputs to clear without a clock.
  task automatic async_reset();
    @(posedge i_clk);
    #3;
    i_nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
  endtask

  task automatic idle(input logic [7:0] ra);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ra, 1'b0, 8'h00);
  endtask

  task automatic run1(input logic br, input logic [7:0] bt);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, br, bt);
  endtask

  // Monitor: compare every queued prediction right after its edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_valid", o_inst_valid, e.valid);
        chk("pc",         o_pc,         e.pc);
        chk("inst",       o_inst,       e.inst);
        chk("halt",       o_halt,       e.halt);
        chk("prog_err",   o_prog_err,   e.err);
        chk("rd_data",    o_rd_data,    e.rd);
        if (o_inst_valid)
          $display("fetch pc=%0d inst=%h halt=%0b err=%0b", o_pc, o_inst, o_halt, o_prog_err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic prog_r;
    model_reset();
    #2 i_nrst = 1'b0;
    #1;
    check_all_zero("reset");
    step_rst();
    step_rst();
    idle(8'h00);

    // Program bytes 0..7; reading the address being written shows the old byte.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 1'b1, 8'(i), 8'(i), 8'(i), 1'b0, 8'h00);
    // Out-of-range write flags an error; readback of address 3.
    step(1'b1, 1'b0, 1'b1, 8'd64, 8'h55, 8'd3, 1'b0, 8'h00);
    idle(8'd64);
    idle(8'd3);

    // Run: fetch 0, branch to 0x0B during o_pc=0 -> 4 then 8.
    run1(1'b0, 8'h00);
    run1(1'b0, 8'h00);
    run1(1'b1, 8'h0B);
    run1(1'b0, 8'h00);
    // Write during run is ignored.
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'hAA, 8'h00, 1'b0, 8'h00);
    // Branch to 60 then wrap to 0, 4.
    run1(1'b1, 8'd60);
    run1(1'b0, 8'h00);
    run1(1'b0, 8'h00);
    run1(1'b0, 8'h00);
    idle(8'h00);
    idle(8'h00);

    // Re-enter programming (clears error), put halt word at word 2.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int a = 8; a < 12; a++)
      step(1'b1, 1'b0, 1'b1, 8'(a), 8'hFF, 8'(a), 1'b0, 8'h00);
    idle(8'd10);
    for (int k = 0; k < 4; k++) run1(1'b0, 8'h00);
    // Halted: out-of-range write outside programming leaves error clear.
    step(1'b0, 1'b1, 1'b1, 8'h90, 8'h12, 8'h00, 1'b0, 8'h00);
    run1(1'b0, 8'h00);
    idle(8'h00);
    for (int k = 0; k < 5; k++) run1(1'b0, 8'h00);
    idle(8'h00);

    // Randomized traffic.
    prog_r = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 14) == 0) prog_r = ~prog_r;
      step(prog_r,
           ($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 79)),
           ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 79)),
           ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 255)));
    end

    // Mid-run reset with non-zero state; afterwards all bytes read zero.
    idle(8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'd12, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(8'h00);
    run1(1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    async_reset();
    step_rst();
    step_rst();
    for (int a = 0; a < 8; a++) idle(8'(a * 9));
    run1(1'b0, 8'h00);
    run1(1'b0, 8'h00);
    idle(8'h00);

    @(posedge i_clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
Parametrised successor to the fixed 8-bit PC plus instruction memory pair. It merges the program counter, a byte-programmable instruction store and a fetch sequencer into one block. The block adds run/program/halt modes, registered fetch with a valid flag, branch redirect, halt detection, programming-port readback and out-of-range error reporting. It sits between the I2C programming slave (byte write/readback port) and the downstream decode logic (o_inst/o_inst_valid).

Parameters:
ADDR_W, 8, byte-address width of PC, write, read and branch addresses
INST_W, 32, instruction width in bits; must be a multiple of 8
DEPTH, 16, number of instruction words stored
PC_STEP, 4, byte increment per sequential fetch; must equal INST_W/8
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts the fetch sequencer

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_nrst  in  1  asynchronous active-low reset
i_prog_mode  in  1  1 = programming requested (highest priority)
i_run  in  1  1 = fetch enabled
i_wr_en  in  1  byte write strobe, honoured only in S_PROG
i_wr_addr  in  ADDR_W  byte address of the write
i_wr_data  in  8  write byte
i_rd_addr  in  ADDR_W  readback byte address
o_rd_data  out  8  readback byte, registered
i_branch_en  in  1  redirect the next fetch
i_branch_target  in  ADDR_W  branch byte address
o_pc  out  ADDR_W  address of the word presented on o_inst
o_inst  out  INST_W  fetched instruction
o_inst_valid  out  1  o_inst valid this cycle
o_halt  out  1  sequencer is halted
o_prog_err  out  1  sticky out-of-range write flag

Behaviour:
- Reset (async, i_nrst=0):
  - State goes to S_IDLE.
  - Internal PC, o_pc, o_inst, o_rd_data and the memory array are all cleared to 0.
  - o_inst_valid, o_halt and o_prog_err are 0.
  - Reset asserted mid-fetch or mid-programming aborts the operation immediately; no partial write survives past the reset edge.
- Derived values: BPI = INST_W/8; SPAN = DEPTH*BPI.
  - Word index = addr / BPI; byte lane = addr % BPI.
  - Little-endian: lane 0 = bits [7:0].
- State priority each cycle: i_prog_mode > halt detection > i_run.
- S_IDLE:
  - i_prog_mode=1 -> S_PROG.
  - Else i_run=1 -> S_RUN, fetching from the current PC.
- S_PROG:
  - On entry, o_prog_err is cleared and the PC is set to 0.
  - i_wr_en=1 with i_wr_addr < SPAN writes the byte at the clock edge.
  - i_wr_en=1 with i_wr_addr >= SPAN writes nothing and sets o_prog_err.
  - i_prog_mode=0 -> S_IDLE.
  - o_inst_valid is 0 throughout.
- S_RUN (fetch latency 1 cycle):
  - Each edge: o_inst <= mem[pc word], o_pc <= pc, o_inst_valid <= 1.
  - Next PC: if i_branch_en=1, i_branch_target with its low log2(BPI) bits forced to 0; else pc+PC_STEP.
  - Next PC always wraps modulo SPAN.
  - A branch asserted in the same cycle as a fetch affects only the following fetch.
  - i_run=0 -> S_IDLE; o_inst_valid drops the next cycle; PC is retained, so i_run=1 resumes.
  - i_prog_mode=1 -> S_PROG; o_inst_valid drops the next cycle.
- Halt:
  - When the word fetched in S_RUN equals HALT_WORD, it is still presented with o_inst_valid=1.
  - o_halt rises on that same edge and the state becomes S_HALT; the PC is not advanced.
  - In S_HALT: o_inst_valid=0, o_halt=1.
  - Exits: i_prog_mode=1 -> S_PROG; i_run=0 -> S_IDLE with PC cleared to 0.
  - o_halt clears on exit.
- Write attempts outside S_PROG are ignored and do not set o_prog_err.
- Readback, any state:
  - o_rd_data <= byte at i_rd_addr every cycle.
  - Out-of-range addresses read 0.
  - Writing and reading the same address in the same cycle returns the old byte; the new value is visible the following cycle.

Decomposition:
- Package prog_fetch_pkg:
  - state enum (S_IDLE, S_PROG, S_RUN, S_HALT);
  - localparam functions for BPI, SPAN and the word-index width;
  - default HALT_WORD constant.
- Sub-module fetch_mem:
  - DEPTH x INST_W flop array, async-cleared;
  - one byte-lane write port;
  - one word read port and one byte read port.
- FSM and PC logic stay in prog_fetch_unit.

Test Plan:
- Program then run: reset, prog_mode=1, write bytes 0x00..0x07 to addrs 0..7, prog_mode=0, run=1 -> first valid o_inst=32'h03020100 with o_pc=0, next o_inst=32'h07060504 with o_pc=4, o_inst_valid high from the second cycle after run.
- Wrap-around: run from PC 60 with DEPTH=16 -> o_pc sequence 60, 0, 4.
- Branch: i_branch_en=1, target=8'h0B during the fetch of o_pc=0 -> the fetch after o_pc=4 has o_pc=8 (low bits masked).
- Halt: word 2 = 0xFFFFFFFF -> o_inst=FFFFFFFF valid at o_pc=8 with o_halt=1 on the same edge; o_inst_valid=0 thereafter; run=0 then run=1 restarts at o_pc=0.
- Programming error and readback:
  - write to addr 64 -> o_prog_err=1, memory unchanged;
  - read addr 3 -> o_rd_data=0x03;
  - write during S_RUN -> ignored;
  - re-enter prog_mode -> o_prog_err=0.
- Mid-operation reset: assert i_nrst=0 during S_RUN -> outputs zero immediately (async); after release, readback of any address returns 0.
